// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - engine-side request/enable handshake and SDRAM pad signals of the arbiter
interface sdram_arbiter_if;
  logic        init_done;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [11:0] init_addr;
  logic        ar_req;
  logic        ar_end;
  logic [3:0]  ar_cmd;
  logic [1:0]  ar_ba;
  logic [11:0] ar_addr;
  logic        wr_req;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [11:0] wr_addr;
  logic [15:0] wr_dq;
  logic        wr_dq_oe;
  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [11:0] rd_addr;
  logic        ar_en;
  logic        wr_en;
  logic        rd_en;
  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        err_timeout;

  modport slave (
    input  init_done, init_cmd, init_ba, init_addr,
    input  ar_req, ar_end, ar_cmd, ar_ba, ar_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq, wr_dq_oe,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output ar_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, err_timeout
  );

  modport master (
    output init_done, init_cmd, init_ba, init_addr,
    output ar_req, ar_end, ar_cmd, ar_ba, ar_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq, wr_dq_oe,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  ar_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, err_timeout
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - grants one SDRAM engine at a time and muxes its command, bank and address onto the pads
module sdram_arbiter #(
  parameter logic [3:0]  CMD_NOP       = 4'b0111,
  parameter logic [9:0]  GRANT_TIMEOUT = 10'd1000,
  parameter logic [1:0]  IDLE_BA       = 2'b11,
  parameter logic [11:0] IDLE_ADDR     = 12'hFFF
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  sdram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

  localparam logic [9:0] CNT_LAST = GRANT_TIMEOUT - 10'd1;

  state_t      state, state_nxt;
  logic        last_wr, last_wr_nxt;
  logic [9:0]  grant_cnt;
  logic        err_q;
  logic        in_grant;
  logic        grant_end;
  logic        timeout_hit;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [11:0] addr;

  assign in_grant    = (state == AREF) || (state == WRITE) || (state == READ);
  assign timeout_hit = (grant_cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= INIT;
      last_wr   <= 1'b0;
      grant_cnt <= 10'd0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_wr <= last_wr_nxt;
      if (!in_grant)
        grant_cnt <= 10'd0;
      else if (grant_cnt != 10'h3FF)
        grant_cnt <= grant_cnt + 10'd1;
      // An end arriving on the timeout cycle is a clean completion, not an error
      if (in_grant && timeout_hit && !grant_end)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_wr_nxt = last_wr;
    grant_end   = 1'b0;
    cmd         = CMD_NOP;
    ba          = IDLE_BA;
    addr        = IDLE_ADDR;
    case (state)
      INIT: begin
        cmd  = bus.init_cmd;
        ba   = bus.init_ba;
        addr = bus.init_addr;
        if (bus.init_done) state_nxt = ARBIT;
      end
      ARBIT: begin
        if (bus.ar_req)                     state_nxt = AREF;
        else if (bus.wr_req && bus.rd_req)  state_nxt = last_wr ? READ : WRITE;
        else if (bus.wr_req)                state_nxt = WRITE;
        else if (bus.rd_req)                state_nxt = READ;
        if (state_nxt == WRITE)     last_wr_nxt = 1'b1;
        else if (state_nxt == READ) last_wr_nxt = 1'b0;
      end
      AREF: begin
        cmd       = bus.ar_cmd;
        ba        = bus.ar_ba;
        addr      = bus.ar_addr;
        grant_end = bus.ar_end;
        if (grant_end || timeout_hit) state_nxt = ARBIT;
      end
      WRITE: begin
        cmd       = bus.wr_cmd;
        ba        = bus.wr_ba;
        addr      = bus.wr_addr;
        grant_end = bus.wr_end;
        if (grant_end || timeout_hit) state_nxt = ARBIT;
      end
      READ: begin
        cmd       = bus.rd_cmd;
        ba        = bus.rd_ba;
        addr      = bus.rd_addr;
        grant_end = bus.rd_end;
        if (grant_end || timeout_hit) state_nxt = ARBIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.ar_en        = (state == AREF);
  assign bus.wr_en        = (state == WRITE);
  assign bus.rd_en        = (state == READ);
  assign bus.sdram_cke    = 1'b1;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
  assign bus.sdram_ba     = ba;
  assign bus.sdram_addr   = addr;
  assign bus.sdram_dq_out = bus.wr_dq;
  assign bus.sdram_dq_oe  = bus.wr_dq_oe && (state == WRITE);
  assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter against an ownership-based reference model
module tb_sdram_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  sdram_arbiter_if bus();
  sdram_arbiter dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

  localparam int O_INIT = 0, O_IDLE = 1, O_AR = 2, O_WR = 3, O_RD = 4;
  localparam int TIMEOUT_CYCLES = 1000;

  typedef struct packed {
    logic [2:0]  grants;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [15:0] dq;
    logic        oe;
    logic        cke;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the bus, how long they have held it, who was served last
  int m_own, m_held, end_at, end_mode;
  bit m_last_wr, m_err, rnd;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = O_INIT; m_held = 0; m_last_wr = 1'b0; m_err = 1'b0;
  endtask

  task automatic scramble();
    bus.init_cmd = 4'($urandom); bus.init_ba = 2'($urandom); bus.init_addr = 12'($urandom);
    bus.ar_cmd   = 4'($urandom); bus.ar_ba   = 2'($urandom); bus.ar_addr   = 12'($urandom);
    bus.wr_cmd   = 4'($urandom); bus.wr_ba   = 2'($urandom); bus.wr_addr   = 12'($urandom);
    bus.rd_cmd   = 4'($urandom); bus.rd_ba   = 2'($urandom); bus.rd_addr   = 12'($urandom);
    bus.wr_dq    = 16'($urandom); bus.wr_dq_oe = 1'($urandom);
  endtask

  task automatic push_expect();
    exp_t e;
    if (!sys_rst_n) model_reset();
    e.grants = {m_own == O_AR, m_own == O_WR, m_own == O_RD};
    e.cmd = 4'b0111; e.ba = 2'b11; e.addr = 12'hFFF;
    case (m_own)
      O_INIT: begin e.cmd = bus.init_cmd; e.ba = bus.init_ba; e.addr = bus.init_addr; end
      O_AR:   begin e.cmd = bus.ar_cmd;   e.ba = bus.ar_ba;   e.addr = bus.ar_addr;   end
      O_WR:   begin e.cmd = bus.wr_cmd;   e.ba = bus.wr_ba;   e.addr = bus.wr_addr;   end
      O_RD:   begin e.cmd = bus.rd_cmd;   e.ba = bus.rd_ba;   e.addr = bus.rd_addr;   end
      default: ;
    endcase
    e.dq  = bus.wr_dq;
    e.oe  = bus.wr_dq_oe && (m_own == O_WR);
    e.cke = 1'b1;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic advance();
    int pick;
    bit fin;
    if (!sys_rst_n) return;
    if (m_own == O_INIT) begin
      if (bus.init_done) m_own = O_IDLE;
    end else if (m_own == O_IDLE) begin
      pick = O_IDLE;
      if (bus.ar_req)                    pick = O_AR;
      else if (bus.wr_req && bus.rd_req) pick = m_last_wr ? O_RD : O_WR;
      else if (bus.wr_req)               pick = O_WR;
      else if (bus.rd_req)               pick = O_RD;
      if (pick != O_IDLE) begin
        m_own  = pick;
        m_held = 0;
        end_at = (end_mode < 0) ? int'($urandom_range(0, 7)) : end_mode;
        if (pick == O_WR) m_last_wr = 1'b1;
        if (pick == O_RD) m_last_wr = 1'b0;
      end
    end else begin
      fin = (m_own == O_AR && bus.ar_end) || (m_own == O_WR && bus.wr_end) ||
            (m_own == O_RD && bus.rd_end);
      if (fin || m_held == TIMEOUT_CYCLES - 1) begin
        if (!fin) m_err = 1'b1;
        m_own = O_IDLE;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic tick();
    push_expect();
    advance();
    @(posedge sys_clk); #1;
  endtask

  task automatic drive();
    bus.ar_end = (m_own == O_AR && m_held == end_at);
    bus.wr_end = (m_own == O_WR && m_held == end_at);
    bus.rd_end = (m_own == O_RD && m_held == end_at);
    if (rnd) begin
      if (m_own != O_AR && $urandom_range(0, 9) == 0) bus.ar_end = 1'b1;
      if (m_own != O_WR && $urandom_range(0, 9) == 0) bus.wr_end = 1'b1;
      if (m_own != O_RD && $urandom_range(0, 9) == 0) bus.rd_end = 1'b1;
      if (m_own == O_AR && bus.ar_end)  bus.ar_req = 1'($urandom_range(0, 1));
      else if (!bus.ar_req && $urandom_range(0, 19) == 0) bus.ar_req = 1'b1;
      if (m_own == O_WR && bus.wr_end)  bus.wr_req = 1'($urandom_range(0, 1));
      else if (!bus.wr_req && $urandom_range(0, 4) == 0) bus.wr_req = 1'b1;
      if (m_own == O_RD && bus.rd_end)  bus.rd_req = 1'($urandom_range(0, 1));
      else if (!bus.rd_req && $urandom_range(0, 4) == 0) bus.rd_req = 1'b1;
    end
    scramble();
    tick();
  endtask

  initial begin
    forever begin
      @(negedge sys_clk);
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("grants", {bus.ar_en, bus.wr_en, bus.rd_en}, mon_e.grants);
        chk("bus", {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                    bus.sdram_ba, bus.sdram_addr}, {mon_e.cmd, mon_e.ba, mon_e.addr});
        chk("data", {bus.sdram_dq_out, bus.sdram_dq_oe, bus.sdram_cke},
                    {mon_e.dq, mon_e.oe, mon_e.cke});
        chk("err_timeout", bus.err_timeout, mon_e.err);
      end
    end
  end

  initial begin
    bus.init_done = 1'b0;
    bus.ar_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.ar_end = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    rnd = 1'b0; end_mode = 5; end_at = 5;
    model_reset();
    scramble();
    @(posedge sys_clk); #1;
    repeat (3) begin scramble(); tick(); end
    sys_rst_n = 1'b1;

    // Init hold: requests toggle but nothing may be granted
    rnd = 1'b1;
    repeat (200) drive();

    // All three request together, then W/R alternation with a fixed 5-cycle burst
    rnd = 1'b0; end_mode = 5;
    bus.ar_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    bus.init_done = 1'b1;
    repeat (40) begin drive(); if (bus.ar_end) bus.ar_req = 1'b0; end

    // Refresh raised mid-write waits for wr_end, then beats the pending read
    repeat (60) begin
      if (m_own == O_WR && m_held == 2) bus.ar_req = 1'b1;
      drive();
      if (bus.ar_end) bus.ar_req = 1'b0;
    end

    rnd = 1'b1; end_mode = -1;
    repeat (3000) drive();

    rnd = 1'b0; end_mode = 5;
    bus.ar_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    repeat (20) drive();

    // wr_end lands exactly on the timeout cycle: clean end, no error
    end_mode = TIMEOUT_CYCLES - 1;
    bus.wr_req = 1'b1;
    repeat (3) drive();
    bus.wr_req = 1'b0;
    repeat (TIMEOUT_CYCLES + 5) drive();
    chk("no_err_on_coincident_end", bus.err_timeout, 0);

    // Read never ends: grant times out and the error sticks
    end_mode = 5000;
    bus.rd_req = 1'b1;
    repeat (3) drive();
    bus.rd_req = 1'b0;
    repeat (TIMEOUT_CYCLES + 5) drive();
    chk("err_after_timeout", bus.err_timeout, 1);

    rnd = 1'b1; end_mode = -1;
    repeat (300) drive();
    chk("err_sticky", bus.err_timeout, 1);

    // Reset in the middle of a write grant with data enabled
    rnd = 1'b0; end_mode = 5;
    bus.ar_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    repeat (20) drive();
    end_mode = 5000;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 20 && !(m_own == O_WR && m_held >= 2); i++) drive();
    bus.ar_end = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    scramble();
    bus.wr_dq_oe = 1'b1;
    chk("wr_en_before_reset", bus.wr_en, 1);
    chk("dq_oe_before_reset", bus.sdram_dq_oe, 1);
    push_expect();
    #6;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_dq_oe", bus.sdram_dq_oe, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_bus_init", {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                         bus.sdram_ba, bus.sdram_addr}, {bus.init_cmd, bus.init_ba, bus.init_addr});
    model_reset();
    @(posedge sys_clk); #1;
    bus.init_done = 1'b0;
    repeat (3) begin scramble(); tick(); end
    sys_rst_n = 1'b1;
    rnd = 1'b1; end_mode = -1;
    repeat (30) drive();
    bus.init_done = 1'b1;
    repeat (300) drive();

    @(negedge sys_clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Central SDRAM command arbiter and the grant side of the request/enable handshake used by the init, auto-refresh, write and read engines.
- Holds the bus for the init engine until init_done is asserted.
- After that, it grants exactly one engine at a time with ar_en, wr_en or rd_en, and muxes the granted engine's command, bank and address onto the SDRAM pins.
- Sits between the engine submodules and the SDRAM pad interface.

Parameters:
- CMD_NOP, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n}
- GRANT_TIMEOUT, 10'd1000, max cycles a grant may stay open without the engine's *_end
- IDLE_BA, 2'b11, bank value driven when no engine is granted
- IDLE_ADDR, 12'hFFF, address value driven when no engine is granted

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst_n  in  1  asynchronous, active-low reset
- init_done  in  1  init sequence complete (stays high once set)
- init_cmd  in  4  init engine command
- init_ba  in  2  init engine bank
- init_addr  in  12  init engine address
- ar_req  in  1  auto-refresh request
- ar_end  in  1  auto-refresh done, single-cycle pulse
- ar_cmd  in  4  auto-refresh command
- ar_ba  in  2  auto-refresh bank
- ar_addr  in  12  auto-refresh address
- wr_req  in  1  write request
- wr_end  in  1  write done, pulse
- wr_cmd  in  4  write command
- wr_ba  in  2  write bank
- wr_addr  in  12  write address
- wr_dq  in  16  write data
- wr_dq_oe  in  1  write engine drives data
- rd_req  in  1  read request
- rd_end  in  1  read done, pulse
- rd_cmd  in  4  read command
- rd_ba  in  2  read bank
- rd_addr  in  12  read address
- ar_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  row address strobe
- sdram_cas_n  out  1  column address strobe
- sdram_we_n  out  1  write enable
- sdram_ba  out  2  bank
- sdram_addr  out  12  address
- sdram_dq_out  out  16  data to pad
- sdram_dq_oe  out  1  pad output enable
- err_timeout  out  1  sticky: a grant timed out

Behaviour:
- Reset values:
  - State = INIT.
  - ar_en, wr_en, rd_en = 0; err_timeout = 0.
  - Grant counter = 0; last_grant = READ.
  - sdram_cke = 1.
- State machine, registered, states INIT, ARBIT, AREF, WRITE, READ:
  - INIT: move to ARBIT when init_done = 1.
  - ARBIT, priority order:
    - ar_req -> AREF.
    - Else, both wr_req and rd_req pending -> the engine not equal to last_grant.
    - Else, wr_req -> WRITE.
    - Else, rd_req -> READ.
    - Else stay in ARBIT.
  - AREF, WRITE, READ: return to ARBIT when the matching *_end = 1, or when the grant counter reaches GRANT_TIMEOUT-1.
  - last_grant updates on entry to WRITE or READ only.
- Grants are decoded from the state register, so there is no glitch:
  - ar_en = (state == AREF); wr_en = (state == WRITE); rd_en = (state == READ).
  - A grant asserts in the cycle after the ARBIT decision.
- No preemption:
  - An ar_req that arrives during WRITE or READ waits until that engine's *_end.
  - Refresh is then granted ahead of any pending write or read.
- Every return to ARBIT spends one cycle in ARBIT before the next grant. The bus drives NOP in that cycle.
- Bus mux is combinational from state:
  - INIT -> init_*.
  - AREF -> ar_*.
  - WRITE -> wr_*.
  - READ -> rd_*.
  - ARBIT -> CMD_NOP, IDLE_BA, IDLE_ADDR.
  - {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = selected 4-bit command.
- Data path:
  - sdram_dq_out = wr_dq at all times.
  - sdram_dq_oe = wr_dq_oe & (state == WRITE), otherwise 0.
- Grant counter:
  - 10 bits; clears in INIT and ARBIT; increments by 1 each cycle in AREF, WRITE and READ; saturates, never wraps.
  - When it reaches GRANT_TIMEOUT-1, the FSM returns to ARBIT and err_timeout sets.
  - err_timeout clears only on reset.
- A *_end from a non-granted engine is ignored. A *_end in the same cycle as a timeout is treated as a normal end and does not set err_timeout.
- A request held high while its own *_end pulses re-arbitrates normally after the one ARBIT cycle.
- Reset asserted mid-grant: all grants drop immediately, the bus drives init_*, and the FSM restarts in INIT.

Test Plan:
- Hold init_done = 0 for 200 cycles while toggling ar_req, wr_req and rd_req -> no grant asserts, and the bus equals init_* every cycle.
- init_done = 1, then assert ar_req, wr_req and rd_req together -> ar_en goes high 1 cycle after ARBIT; bus equals ar_*. Then ar_end pulses -> 1 NOP cycle with ba = 2'b11 and addr = 12'hFFF, then wr_en.
- Hold wr_req and rd_req both high, and pulse each *_end 5 cycles after its grant -> grants alternate W, R, W, R.
- Raise ar_req 2 cycles into WRITE -> wr_en holds until wr_end, then ar_en is granted before a pending rd_req.
- Grant rd_en and never pulse rd_end -> after 1000 cycles in READ, FSM returns to ARBIT and err_timeout = 1, sticky until reset.
- Assert sys_rst_n = 0 while wr_en = 1 and wr_dq_oe = 1 -> wr_en = 0, sdram_dq_oe = 0 and err_timeout = 0 immediately; the FSM then waits for init_done again.
